// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA add/subtract unit.
// The slave side is the arithmetic unit; the master side is issue/writeback.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add1;
  logic [WIDTH-1:0] i_add2;
  logic             i_sub;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
  logic             o_of;
  logic             o_zero;

  modport master (
    output i_valid, i_add1, i_add2, i_sub, i_cin, i_ready,
    input  o_ready, o_valid, o_result, o_cout, o_of, o_zero
  );

  modport slave (
    input  i_valid, i_add1, i_add2, i_sub, i_cin, i_ready,
    output o_ready, o_valid, o_result, o_cout, o_of, o_zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead add/subtract: one SEG_WIDTH segment resolved per
// stage, carry registered between stages, global stall on output backpressure.

module pipelined_cla_addsub_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W-1:0] g, p;
  logic [W:0]   c;
  logic         acc, pp;

  assign g = a & b;
  assign p = a | b;

  // Each carry is a flat sum-of-products over the segment, not a ripple chain.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
  end

  assign s  = a ^ b ^ c[W-1:0];
  assign co = c[W];
endmodule

module pipelined_cla_addsub #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pipelined_cla_addsub_if.slave bus
);
  localparam int NSEG = (SEG_WIDTH < 1) ? 1 : WIDTH / SEG_WIDTH;

  if (SEG_WIDTH < 1 || (WIDTH % SEG_WIDTH) != 0) begin : g_bad_cfg
    $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of SEG_WIDTH");
  end

  // a/b travel skewed with the transaction; s accumulates finished slices.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } rank_t;

  rank_t                           rank_q [NSEG];
  rank_t                           nxt    [NSEG];
  logic [NSEG:0]                   vld_pipe;
  logic [NSEG-1:0][SEG_WIDTH-1:0]  seg_s;
  logic [NSEG-1:0]                 seg_c;
  logic                            adv;
  logic [WIDTH-1:0]                b_eff;
  logic                            c0;
  rank_t                           fin;
  logic                            of_d;
  logic [WIDTH-1:0]                result_q;
  logic                            cout_q, of_q, zero_q;

  assign adv         = ~vld_pipe[NSEG] | bus.i_ready;
  assign bus.o_ready = adv;
  assign bus.o_valid = vld_pipe[NSEG];
  assign bus.o_result = result_q;
  assign bus.o_cout  = cout_q;
  assign bus.o_of    = of_q;
  assign bus.o_zero  = zero_q;

  assign b_eff = bus.i_add2 ^ {WIDTH{bus.i_sub}};
  assign c0    = bus.i_sub | bus.i_cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    pipelined_cla_addsub_seg #(.W(SEG_WIDTH)) u_seg (
      .a  (rank_q[k].a[k*SEG_WIDTH +: SEG_WIDTH]),
      .b  (rank_q[k].b[k*SEG_WIDTH +: SEG_WIDTH]),
      .ci (rank_q[k].c),
      .s  (seg_s[k]),
      .co (seg_c[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      nxt[k] = rank_q[k];
      nxt[k].s[k*SEG_WIDTH +: SEG_WIDTH] = seg_s[k];
      nxt[k].c = seg_c[k];
    end
  end

  assign fin  = nxt[NSEG-1];
  assign of_d = (fin.a[WIDTH-1] == fin.b[WIDTH-1]) & (fin.s[WIDTH-1] != fin.a[WIDTH-1]);

  // Reset wins over acceptance, so operands offered during reset are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      for (int k = 0; k < NSEG; k++) rank_q[k] <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      of_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[NSEG-1:0], bus.i_valid};
      rank_q[0] <= '{a: bus.i_add1, b: b_eff, s: '0, c: c0};
      for (int k = 1; k < NSEG; k++) rank_q[k] <= nxt[k-1];
      result_q  <= fin.s;
      cout_q    <= fin.c;
      of_q      <= of_d;
      zero_q    <= ~|fin.s;
    end
  end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench: directed vectors on the 32/8 build, model-checked sweeps
// on 16/16 and 64/4 builds.
module tb_pipelined_cla_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit done_m = 0, done16 = 0, done64 = 0;

  typedef struct packed {logic [31:0] r; logic c; logic o; logic z;} exp32_t;
  typedef struct packed {logic [63:0] r; logic c; logic o; logic z;} exp64_t;
  typedef struct {logic [31:0] a; logic [31:0] b; logic sub; logic cin; exp32_t e;} vec_t;

  exp32_t q32[$];
  exp64_t q16[$];
  exp64_t q64[$];
  vec_t   sv[6];

  pipelined_cla_addsub_if #(.WIDTH(32)) bm ();
  pipelined_cla_addsub_if #(.WIDTH(16)) b16 ();
  pipelined_cla_addsub_if #(.WIDTH(64)) b64 ();

  pipelined_cla_addsub #(.WIDTH(32), .SEG_WIDTH(8))  u_dut   (.i_clk(clk), .i_rst(rst),   .bus(bm));
  pipelined_cla_addsub #(.WIDTH(16), .SEG_WIDTH(16)) u_dut16 (.i_clk(clk), .i_rst(rst_s), .bus(b16));
  pipelined_cla_addsub #(.WIDTH(64), .SEG_WIDTH(4))  u_dut64 (.i_clk(clk), .i_rst(rst_s), .bus(b64));

  task automatic check(input string name, input logic ok, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp64_t model16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
    logic [15:0] bb;
    logic [16:0] s;
    bb = b ^ {16{sub}};
    s  = {1'b0, a} + {1'b0, bb} + {16'd0, sub | cin};
    return '{r: {48'd0, s[15:0]}, c: s[16], o: (a[15] == bb[15]) && (s[15] != a[15]), z: s[15:0] == 16'd0};
  endfunction

  function automatic exp64_t model64(input logic [63:0] a, input logic [63:0] b, input logic sub, input logic cin);
    logic [63:0] bb;
    logic [64:0] s;
    bb = b ^ {64{sub}};
    s  = {1'b0, a} + {1'b0, bb} + {64'd0, sub | cin};
    return '{r: s[63:0], c: s[64], o: (a[63] == bb[63]) && (s[63] != a[63]), z: s[63:0] == 64'd0};
  endfunction

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin, input exp32_t e);
    int n;
    n = 0;
    @(negedge clk);
    bm.i_add1 = a; bm.i_add2 = b; bm.i_sub = sub; bm.i_cin = cin;
    bm.i_valid = 1'b1; bm.i_ready = 1'b1;
    #1;
    while (!bm.o_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("issue_ready", bm.o_ready == 1'b1, bm.o_ready, 1);
    if (bm.o_ready) q32.push_back(e);
    @(posedge clk);
    #1 bm.i_valid = 1'b0;
  endtask

  task automatic drain32();
    int n;
    n = 0;
    while (q32.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check("drain32", q32.size() == 0, q32.size(), 0);
  endtask

  // Main monitor: pops on every output handshake, checks hold during stalls.
  initial begin
    exp32_t e, h, cur;
    bit hv;
    hv = 0;
    forever begin
      @(negedge clk); #2;
      cur = '{r: bm.o_result, c: bm.o_cout, o: bm.o_of, z: bm.o_zero};
      if (rst) hv = 0;
      else if (bm.o_valid) begin
        if (hv) check("hold", cur == h, cur, h);
        if (bm.i_ready) begin
          hv = 0;
          check("stale_result", q32.size() != 0, cur, 0);
          if (q32.size() != 0) begin
            e = q32.pop_front();
            check("result32", cur == e, cur, e);
          end
        end else begin
          h = cur; hv = 1;
        end
      end else hv = 0;
    end
  end

  // Main directed stimulus.
  initial begin
    int lat;
    bit saw;
    sv[0] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, '{32'h23456789, 1'b0, 1'b0, 1'b0}};
    sv[1] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}};
    sv[2] = '{32'h00000010, 32'h00000020, 1'b1, 1'b0, '{32'hFFFFFFF0, 1'b0, 1'b0, 1'b0}};
    sv[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
    sv[4] = '{32'hDEADBEEF, 32'h00000001, 1'b0, 1'b1, '{32'hDEADBEF1, 1'b0, 1'b0, 1'b0}};
    sv[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
    bm.i_valid = 0; bm.i_ready = 1; bm.i_add1 = '0; bm.i_add2 = '0; bm.i_sub = 0; bm.i_cin = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    #1;
    check("reset_outputs", {bm.o_valid, bm.o_result, bm.o_cout, bm.o_of, bm.o_zero} == '0,
          {bm.o_valid, bm.o_result, bm.o_cout, bm.o_of, bm.o_zero}, 0);
    check("reset_ready", bm.o_ready == 1'b1, bm.o_ready, 1);

    issue32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0});
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bm.o_valid && lat < 20);
    check("latency32", lat == 4, lat, 4);
    issue32(32'h00000005, 32'h00000005, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1});
    issue32(32'h00000000, 32'h00000001, 1'b1, 1'b1, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
    issue32(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1});
    drain32();

    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        repeat (3) begin
          @(negedge clk); bm.i_ready = 1'b0; #1;
          check("stall_ready", bm.o_ready == 1'b0, bm.o_ready, 0);
        end
      end
      issue32(sv[i].a, sv[i].b, sv[i].sub, sv[i].cin, sv[i].e);
    end
    drain32();

    for (int i = 0; i < 3; i++) issue32(sv[i].a, sv[i].b, sv[i].sub, sv[i].cin, sv[i].e);
    @(negedge clk);
    rst = 1'b1;
    bm.i_valid = 1'b1; bm.i_add1 = 32'h1; bm.i_add2 = 32'h1; bm.i_sub = 1'b0;
    q32.delete();
    @(negedge clk); #1;
    check("midreset_outputs", {bm.o_valid, bm.o_result, bm.o_cout, bm.o_of, bm.o_zero} == '0,
          {bm.o_valid, bm.o_result, bm.o_cout, bm.o_of, bm.o_zero}, 0);
    rst = 1'b0; bm.i_valid = 1'b0; #1;
    check("midreset_ready", bm.o_ready == 1'b1, bm.o_ready, 1);
    saw = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (bm.o_valid) saw = 1;
    end
    check("midreset_no_stale", saw == 1'b0, saw, 0);
    done_m = 1;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst_s = 0;
  end

  // 16/16 sweep: latency 1, random traffic and backpressure.
  initial begin
    logic [15:0] a, b;
    logic sub, cin;
    int sent, lat, n;
    b16.i_valid = 0; b16.i_ready = 1; b16.i_add1 = '0; b16.i_add2 = '0; b16.i_sub = 0; b16.i_cin = 0;
    while (rst_s) @(negedge clk);
    @(negedge clk);
    b16.i_add1 = 16'h7FFF; b16.i_add2 = 16'h0001; b16.i_valid = 1; #1;
    if (b16.o_ready) q16.push_back(model16(16'h7FFF, 16'h0001, 1'b0, 1'b0));
    @(posedge clk); #1 b16.i_valid = 0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!b16.o_valid && lat < 40);
    check("latency16", lat == 1, lat, 1);
    sent = 0; n = 0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    while (sent < 1000 && n < 20000) begin
      @(negedge clk);
      b16.i_ready = ($urandom_range(0, 3) != 0);
      b16.i_valid = ($urandom_range(0, 3) != 0);
      b16.i_add1 = a; b16.i_add2 = b; b16.i_sub = sub; b16.i_cin = cin;
      #1;
      if (b16.i_valid && b16.o_ready) begin
        q16.push_back(model16(a, b, sub, cin));
        sent++;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
      n++;
    end
    @(negedge clk); b16.i_valid = 0; b16.i_ready = 1;
    n = 0;
    while (q16.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check("sweep16_drain", q16.size() == 0 && sent == 1000, sent, 1000);
    done16 = 1;
  end

  // 64/4 sweep: latency 16, random traffic and backpressure.
  initial begin
    logic [63:0] a, b;
    logic sub, cin;
    int sent, lat, n;
    b64.i_valid = 0; b64.i_ready = 1; b64.i_add1 = '0; b64.i_add2 = '0; b64.i_sub = 0; b64.i_cin = 0;
    while (rst_s) @(negedge clk);
    @(negedge clk);
    b64.i_add1 = 64'hFFFFFFFFFFFFFFFF; b64.i_add2 = 64'h0; b64.i_cin = 1; b64.i_valid = 1; #1;
    if (b64.o_ready) q64.push_back(model64(64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b1));
    @(posedge clk); #1 b64.i_valid = 0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!b64.o_valid && lat < 40);
    check("latency64", lat == 16, lat, 16);
    sent = 0; n = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom); cin = 1'($urandom);
    while (sent < 1000 && n < 20000) begin
      @(negedge clk);
      b64.i_ready = ($urandom_range(0, 3) != 0);
      b64.i_valid = ($urandom_range(0, 3) != 0);
      b64.i_add1 = a; b64.i_add2 = b; b64.i_sub = sub; b64.i_cin = cin;
      #1;
      if (b64.i_valid && b64.o_ready) begin
        q64.push_back(model64(a, b, sub, cin));
        sent++;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom); cin = 1'($urandom);
      end
      n++;
    end
    @(negedge clk); b64.i_valid = 0; b64.i_ready = 1;
    n = 0;
    while (q64.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("sweep64_drain", q64.size() == 0 && sent == 1000, sent, 1000);
    done64 = 1;
  end

  // Sweep monitors.
  initial begin
    exp64_t e, cur;
    forever begin
      @(negedge clk); #2;
      if (!rst_s && b16.o_valid && b16.i_ready) begin
        cur = '{r: {48'd0, b16.o_result}, c: b16.o_cout, o: b16.o_of, z: b16.o_zero};
        check("sweep16_stale", q16.size() != 0, cur, 0);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          check("sweep16", cur == e, cur, e);
        end
      end
    end
  end

  initial begin
    exp64_t e, cur;
    forever begin
      @(negedge clk); #2;
      if (!rst_s && b64.o_valid && b64.i_ready) begin
        cur = '{r: b64.o_result, c: b64.o_cout, o: b64.o_of, z: b64.o_zero};
        check("sweep64_stale", q64.size() != 0, cur, 0);
        if (q64.size() != 0) begin
          e = q64.pop_front();
          check("sweep64", cur == e, cur, e);
        end
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done_m && done16 && done64) && n < 60000) begin
      @(posedge clk); n++;
    end
    if (!(done_m && done16 && done64)) begin
      failures++;
      $display("FAIL watchdog got=%0d%0d%0d exp=111", done_m, done16, done64);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
